// File: rtl/scoreboard_retire_queue_if.sv
// Issue, writeback and commit bundle between the pipeline and the retire queue.
// master drives issue/writeback/ack; slave (the queue) drives ready, ids, commit data and usage.
interface scoreboard_retire_queue_if #(
   parameter int NR_ENTRIES  = 8,
   parameter int NR_WB_PORTS = 2
);
   localparam int IDW = $clog2(NR_ENTRIES);

   logic                               flush_i;
   logic                               issue_valid_i;
   logic                               issue_ready_o;
   logic [63:0]                        issue_pc_i;
   logic [4:0]                         issue_rd_i;
   logic [3:0]                         issue_fu_i;
   logic [IDW-1:0]                     issue_trans_id_o;

   logic [NR_WB_PORTS-1:0]             wb_valid_i;
   logic [NR_WB_PORTS-1:0][IDW-1:0]    wb_trans_id_i;
   logic [NR_WB_PORTS-1:0][63:0]       wb_result_i;
   logic [NR_WB_PORTS-1:0]             wb_ex_valid_i;
   logic [NR_WB_PORTS-1:0][63:0]       wb_ex_cause_i;

   logic [1:0]                         commit_valid_o;
   logic [1:0][63:0]                   commit_pc_o;
   logic [1:0][4:0]                    commit_rd_o;
   logic [1:0][3:0]                    commit_fu_o;
   logic [1:0][63:0]                   commit_result_o;
   logic [1:0]                         commit_ex_valid_o;
   logic [1:0][63:0]                   commit_ex_cause_o;
   logic [1:0][IDW-1:0]                commit_trans_id_o;
   logic [1:0]                         commit_ack_i;
   logic [IDW:0]                       usage_o;

   modport master (
      output flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_fu_i,
             wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i, wb_ex_cause_i,
             commit_ack_i,
      input  issue_ready_o, issue_trans_id_o, commit_valid_o, commit_pc_o, commit_rd_o,
             commit_fu_o, commit_result_o, commit_ex_valid_o, commit_ex_cause_o,
             commit_trans_id_o, usage_o
   );

   modport slave (
      input  flush_i, issue_valid_i, issue_pc_i, issue_rd_i, issue_fu_i,
             wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i, wb_ex_cause_i,
             commit_ack_i,
      output issue_ready_o, issue_trans_id_o, commit_valid_o, commit_pc_o, commit_rd_o,
             commit_fu_o, commit_result_o, commit_ex_valid_o, commit_ex_cause_o,
             commit_trans_id_o, usage_o
   );
endinterface

// File: rtl/scoreboard_retire_queue.sv
// In-order retire queue: issue allocates the tail, writebacks complete slots, up to two DONE heads retire.
// Commit is visible one cycle after writeback (registered only); issue is refused while full, regardless of acks.
module scoreboard_retire_queue #(
   parameter int NR_ENTRIES  = 8,
   parameter int NR_WB_PORTS = 2
) (
   input logic                        clk_i,
   input logic                        rst_i,
   scoreboard_retire_queue_if.slave   sb
);
   localparam int IDW = $clog2(NR_ENTRIES);
   localparam logic [IDW:0] FULL_CNT = NR_ENTRIES[IDW:0];

   typedef enum logic [1:0] {
      SLOT_FREE   = 2'd0,
      SLOT_ISSUED = 2'd1,
      SLOT_DONE   = 2'd2
   } slot_state_e;

   slot_state_e     state_q [NR_ENTRIES];
   slot_state_e     state_d [NR_ENTRIES];
   logic [63:0]     pc_q       [NR_ENTRIES];
   logic [4:0]      rd_q       [NR_ENTRIES];
   logic [3:0]      fu_q       [NR_ENTRIES];
   logic [63:0]     result_q   [NR_ENTRIES];
   logic            ex_valid_q [NR_ENTRIES];
   logic [63:0]     ex_cause_q [NR_ENTRIES];

   logic [IDW-1:0]  head_q, head_d, tail_q, tail_d, head_nxt;
   logic [IDW:0]    count_q, count_d;
   logic [IDW-1:0]  commit_idx [2];
   logic [1:0]      commit_vld;
   logic            issue_rdy, issue_fire, ack0, ack1;
   logic [1:0]      pop_cnt;
   logic [NR_WB_PORTS-1:0] wb_eff;

   assign head_nxt      = head_q + IDW'(1);
   assign commit_idx[0] = head_q;
   assign commit_idx[1] = head_nxt;

   // Port 1 only retires alongside port 0 and never next to an excepting entry.
   assign commit_vld[0] = (state_q[head_q] == SLOT_DONE);
   assign commit_vld[1] = commit_vld[0] && (state_q[head_nxt] == SLOT_DONE)
                          && !ex_valid_q[head_q] && !ex_valid_q[head_nxt];

   assign issue_rdy  = (count_q < FULL_CNT) && !sb.flush_i;
   assign issue_fire = sb.issue_valid_i && issue_rdy;
   assign ack0       = sb.commit_ack_i[0] && commit_vld[0];
   assign ack1       = sb.commit_ack_i[1] && commit_vld[1] && ack0;
   assign pop_cnt    = {1'b0, ack0} + {1'b0, ack1};

   // A writeback counts only on an ISSUED slot, and only if no lower port hits the same slot.
   always_comb begin
      wb_eff = '0;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
         wb_eff[p] = sb.wb_valid_i[p] && (state_q[sb.wb_trans_id_i[p]] == SLOT_ISSUED);
         for (int q = 0; q < p; q++) begin
            if (sb.wb_valid_i[q] && (sb.wb_trans_id_i[q] == sb.wb_trans_id_i[p])) begin
               wb_eff[p] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (sb.flush_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) state_d[i] = SLOT_FREE;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_eff[p]) state_d[sb.wb_trans_id_i[p]] = SLOT_DONE;
         end
         if (issue_fire) begin
            state_d[tail_q] = SLOT_ISSUED;
            tail_d          = tail_q + IDW'(1);
         end
         if (ack0) state_d[head_q]   = SLOT_FREE;
         if (ack1) state_d[head_nxt] = SLOT_FREE;
         head_d  = head_q + IDW'(pop_cnt);
         count_d = count_q + (IDW+1)'(issue_fire) - (IDW+1)'(pop_cnt);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NR_ENTRIES; i++) state_q[i] <= SLOT_FREE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload is only meaningful while its slot is not FREE, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (issue_fire) begin
         pc_q[tail_q]       <= sb.issue_pc_i;
         rd_q[tail_q]       <= sb.issue_rd_i;
         fu_q[tail_q]       <= sb.issue_fu_i;
         ex_valid_q[tail_q] <= 1'b0;
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
         if (wb_eff[p] && !sb.flush_i) begin
            result_q[sb.wb_trans_id_i[p]]   <= sb.wb_result_i[p];
            ex_valid_q[sb.wb_trans_id_i[p]] <= sb.wb_ex_valid_i[p];
            ex_cause_q[sb.wb_trans_id_i[p]] <= sb.wb_ex_cause_i[p];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         sb.commit_pc_o[k]       = pc_q[commit_idx[k]];
         sb.commit_rd_o[k]       = rd_q[commit_idx[k]];
         sb.commit_fu_o[k]       = fu_q[commit_idx[k]];
         sb.commit_result_o[k]   = result_q[commit_idx[k]];
         sb.commit_ex_valid_o[k] = ex_valid_q[commit_idx[k]];
         sb.commit_ex_cause_o[k] = ex_cause_q[commit_idx[k]];
         sb.commit_trans_id_o[k] = commit_idx[k];
      end
   end

   assign sb.commit_valid_o   = commit_vld;
   assign sb.issue_ready_o    = issue_rdy;
   assign sb.issue_trans_id_o = tail_q;
   assign sb.usage_o          = count_q;
endmodule

// File: tb/tb_scoreboard_retire_queue.sv
// Bench for scoreboard_retire_queue: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a slot-array reference model.
module tb_scoreboard_retire_queue;
   localparam int N = 8;
   localparam int P = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   scoreboard_retire_queue_if #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) sif ();
   scoreboard_retire_queue #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .sb    (sif)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: 0=free 1=issued 2=done
   int          m_st   [N];
   logic [63:0] m_pc   [N];
   logic [4:0]  m_rd   [N];
   logic [3:0]  m_fu   [N];
   logic [63:0] m_res  [N];
   bit          m_ex   [N];
   logic [63:0] m_cause[N];
   int          m_head, m_tail, m_cnt;
   bit          m_live = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic bit mv0();
      return m_st[m_head] == 2;
   endfunction

   function automatic bit mv1();
      int h1;
      h1 = (m_head + 1) % N;
      return mv0() && m_st[h1] == 2 && !m_ex[m_head] && !m_ex[h1];
   endfunction

   task automatic compare();
      int idx;
      if (!m_live) return;
      chk("usage", sif.usage_o, m_cnt);
      chk("issue_ready", sif.issue_ready_o, (m_cnt < N) && !sif.flush_i);
      chk("issue_tid", sif.issue_trans_id_o, m_tail);
      chk("commit_valid", sif.commit_valid_o, {mv1(), mv0()});
      for (int k = 0; k < 2; k++) begin
         if (k == 0 ? mv0() : mv1()) begin
            idx = (m_head + k) % N;
            chk("c_tid", sif.commit_trans_id_o[k], idx);
            chk("c_pc", sif.commit_pc_o[k], m_pc[idx]);
            chk("c_rd", sif.commit_rd_o[k], m_rd[idx]);
            chk("c_fu", sif.commit_fu_o[k], m_fu[idx]);
            chk("c_result", sif.commit_result_o[k], m_res[idx]);
            chk("c_exv", sif.commit_ex_valid_o[k], m_ex[idx]);
            if (m_ex[idx]) chk("c_cause", sif.commit_ex_cause_o[k], m_cause[idx]);
         end
      end
   endtask

   task automatic model_step();
      bit a0, a1, iss;
      bit taken[N];
      int id, pops;
      if (rst || sif.flush_i) begin
         for (int i = 0; i < N; i++) m_st[i] = 0;
         m_head = 0; m_tail = 0; m_cnt = 0;
         if (rst) m_live = 1;
         return;
      end
      a0  = sif.commit_ack_i[0] && mv0();
      a1  = sif.commit_ack_i[1] && mv1() && a0;
      iss = sif.issue_valid_i && (m_cnt < N);
      for (int i = 0; i < N; i++) taken[i] = 0;
      for (int p = 0; p < P; p++) begin
         if (sif.wb_valid_i[p]) begin
            id = int'(sif.wb_trans_id_i[p]);
            if (!taken[id]) begin
               taken[id] = 1;
               if (m_st[id] == 1) begin
                  m_st[id]    = 2;
                  m_res[id]   = sif.wb_result_i[p];
                  m_ex[id]    = sif.wb_ex_valid_i[p];
                  m_cause[id] = sif.wb_ex_cause_i[p];
               end
            end
         end
      end
      pops = int'(a0) + int'(a1);
      for (int k = 0; k < pops; k++) m_st[(m_head + k) % N] = 0;
      m_head = (m_head + pops) % N;
      if (iss) begin
         m_st[m_tail] = 1;
         m_pc[m_tail] = sif.issue_pc_i;
         m_rd[m_tail] = sif.issue_rd_i;
         m_fu[m_tail] = sif.issue_fu_i;
         m_ex[m_tail] = 0;
         m_tail = (m_tail + 1) % N;
      end
      m_cnt = m_cnt + int'(iss) - pops;
   endtask

   // Called at the falling edge with inputs applied; ends at the next falling edge.
   task automatic tick();
      #1;
      compare();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      rst                = 1'b0;
      sif.flush_i        = 1'b0;
      sif.issue_valid_i  = 1'b0;
      sif.issue_pc_i     = '0;
      sif.issue_rd_i     = '0;
      sif.issue_fu_i     = '0;
      sif.wb_valid_i     = '0;
      sif.wb_trans_id_i  = '0;
      sif.wb_result_i    = '0;
      sif.wb_ex_valid_i  = '0;
      sif.wb_ex_cause_i  = '0;
      sif.commit_ack_i   = '0;
   endtask

   task automatic set_issue(input logic [63:0] pc);
      sif.issue_valid_i = 1'b1;
      sif.issue_pc_i    = pc;
      sif.issue_rd_i    = pc[4:0];
      sif.issue_fu_i    = pc[7:4];
   endtask

   task automatic set_wb(input int p, input int id, input logic [63:0] res,
                         input bit ex, input logic [63:0] cause);
      sif.wb_valid_i[p]    = 1'b1;
      sif.wb_trans_id_i[p] = 3'(id);
      sif.wb_result_i[p]   = res;
      sif.wb_ex_valid_i[p] = ex;
      sif.wb_ex_cause_i[p] = cause;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic issue_n(input int n, input logic [63:0] base);
      for (int i = 0; i < n; i++) begin
         clear_inputs();
         set_issue(base + 64'(i));
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);
      do_reset();
      chk("rst_usage", sif.usage_o, 0);
      chk("rst_cvalid", sif.commit_valid_o, 0);
      chk("rst_tid", sif.issue_trans_id_o, 0);
      chk("rst_ready", sif.issue_ready_o, 1);

      // Dual retire in order after out-of-order writeback
      for (int i = 0; i < 3; i++) begin
         clear_inputs();
         set_issue(64'h100 + 64'(i));
         chk("seq_tid", sif.issue_trans_id_o, i);
         tick();
      end
      clear_inputs(); set_wb(0, 1, 64'h11, 0, 0); tick();
      chk("ooo_wait", sif.commit_valid_o, 2'b00);
      clear_inputs(); set_wb(0, 0, 64'h10, 0, 0); tick();
      chk("dual_valid", sif.commit_valid_o, 2'b11);
      chk("dual_tid0", sif.commit_trans_id_o[0], 0);
      chk("dual_tid1", sif.commit_trans_id_o[1], 1);
      chk("dual_res0", sif.commit_result_o[0], 64'h10);
      chk("dual_res1", sif.commit_result_o[1], 64'h11);
      chk("dual_usage", sif.usage_o, 3);
      clear_inputs(); sif.commit_ack_i = 2'b11; tick();
      chk("dual_pop_usage", sif.usage_o, 1);
      chk("dual_pop_cvalid", sif.commit_valid_o, 2'b00);
      clear_inputs(); set_wb(1, 2, 64'h12, 0, 0); tick();
      chk("id2_valid", sif.commit_valid_o, 2'b01);
      chk("id2_tid", sif.commit_trans_id_o[0], 2);
      chk("id2_pc", sif.commit_pc_o[0], 64'h102);
      clear_inputs(); sif.commit_ack_i = 2'b01; tick();
      chk("id2_pop_usage", sif.usage_o, 0);

      // Full queue refuses issue even while popping; then wraps to id0
      do_reset();
      issue_n(8, 64'h200);
      chk("full_ready", sif.issue_ready_o, 0);
      chk("full_usage", sif.usage_o, 8);
      set_wb(0, 0, 64'h20, 0, 0); tick();
      clear_inputs(); sif.commit_ack_i = 2'b01; set_issue(64'h2ff); tick();
      clear_inputs();
      chk("full_refused_usage", sif.usage_o, 7);
      chk("full_ready_after", sif.issue_ready_o, 1);
      chk("wrap_tid", sif.issue_trans_id_o, 0);
      set_issue(64'h300); tick(); clear_inputs();
      chk("wrap_usage", sif.usage_o, 8);

      // Exception at head blocks the second commit port
      do_reset();
      issue_n(2, 64'h600);
      set_wb(0, 0, 64'h0, 1, 64'h2); set_wb(1, 1, 64'h33, 0, 0); tick(); clear_inputs();
      chk("ex_cvalid", sif.commit_valid_o, 2'b01);
      chk("ex_valid0", sif.commit_ex_valid_o[0], 1);
      chk("ex_cause0", sif.commit_ex_cause_o[0], 64'h2);

      // ack[1] without ack[0] is ignored
      do_reset();
      issue_n(2, 64'h700);
      set_wb(0, 0, 64'h70, 0, 0); set_wb(1, 1, 64'h71, 0, 0); tick(); clear_inputs();
      chk("ack10_pre", sif.commit_valid_o, 2'b11);
      sif.commit_ack_i = 2'b10; tick(); clear_inputs();
      chk("ack10_usage", sif.usage_o, 2);
      chk("ack10_cvalid", sif.commit_valid_o, 2'b11);

      // Flush beats concurrent issue, writeback and ack
      do_reset();
      issue_n(5, 64'h800);
      set_wb(0, 0, 64'h80, 0, 0); tick(); clear_inputs();
      sif.flush_i = 1'b1; set_issue(64'h8ff); set_wb(0, 1, 64'h81, 0, 0);
      sif.commit_ack_i = 2'b11; tick(); clear_inputs();
      chk("flush_usage", sif.usage_o, 0);
      chk("flush_cvalid", sif.commit_valid_o, 2'b00);
      chk("flush_tid", sif.issue_trans_id_o, 0);

      // Writebacks to FREE and DONE slots are dropped; lower port wins a collision
      do_reset();
      set_wb(0, 0, 64'hAA, 0, 0); tick(); clear_inputs();
      set_issue(64'h400); tick(); clear_inputs();
      tick();
      chk("free_wb_ignored", sif.commit_valid_o, 2'b00);
      set_wb(0, 0, 64'h55, 0, 0); tick(); clear_inputs();
      set_wb(1, 0, 64'h77, 0, 0); tick(); clear_inputs();
      chk("dup_cvalid", sif.commit_valid_o, 2'b01);
      chk("dup_result", sif.commit_result_o[0], 64'h55);
      set_issue(64'h401); tick(); clear_inputs();
      set_wb(0, 1, 64'h1, 0, 0); set_wb(1, 1, 64'h2, 0, 0); tick(); clear_inputs();
      chk("prio_cvalid", sif.commit_valid_o, 2'b11);
      chk("prio_result", sif.commit_result_o[1], 64'h1);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         clear_inputs();
         if ($urandom_range(99) == 0) rst = 1'b1;
         if ($urandom_range(49) == 0) sif.flush_i = 1'b1;
         if ($urandom_range(2) != 0) set_issue({$urandom, $urandom});
         for (int p = 0; p < P; p++) begin
            if ($urandom_range(1) != 0) begin
               int id;
               if (m_cnt > 0 && $urandom_range(3) != 0)
                  id = (m_head + int'($urandom_range(m_cnt - 1))) % N;
               else
                  id = int'($urandom_range(N - 1));
               set_wb(p, id, {$urandom, $urandom}, $urandom_range(5) == 0, 64'($urandom));
            end
         end
         sif.commit_ack_i = 2'($urandom);
         tick();
      end
      clear_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
